// File: rtl/dram_arb_pkg.sv
// Shared types and default sizes for the DRAM port arbiter.
// The block typedef is one cache line, as carried on every port.
package dram_arb_pkg;

    localparam int DRAM_ADDRESS_SIZE = 24;
    localparam int DRAM_WORD_SIZE    = 32;
    localparam int DRAM_BLOCK_SIZE   = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT1,
        ARB_GRANT2,
        ARB_DONE
    } arb_state_t;

    typedef enum logic {
        PORT1,
        PORT2
    } port_id_t;

    typedef logic [DRAM_WORD_SIZE-1:0] dram_block_t [DRAM_BLOCK_SIZE];

endpackage

// File: rtl/dram_arb_watchdog.sv
// Saturating transfer watchdog. The count reaches TIMEOUT_CYCLES-1 on the
// last tolerated GRANT cycle, and expired registers one edge later.
module dram_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             expired_q, expired_d;

    always_comb begin
        count_d   = count_q;
        expired_d = expired_q;
        if (clear) begin
            count_d   = '0;
            expired_d = 1'b0;
        end else if (enable) begin
            expired_d = expired_q || (count_q == LAST);
            if (count_q != LAST) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin sequencer of the single DRAM block port between the icache
// refill port (p1, read-only) and the dcache refill/writeback port (p2).
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W         = DRAM_ADDRESS_SIZE,
    parameter int WORD_W         = DRAM_WORD_SIZE,
    parameter int BLOCK_WORDS    = DRAM_BLOCK_SIZE,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p1_request,
    input  logic [ADDR_W-1:0] p1_address,
    output logic [WORD_W-1:0] p1_read_data [BLOCK_WORDS],
    output logic              p1_acknowledge,
    input  logic              p2_request,
    input  logic [ADDR_W-1:0] p2_address,
    input  logic              p2_we,
    input  logic [WORD_W-1:0] p2_write_data [BLOCK_WORDS],
    output logic [WORD_W-1:0] p2_read_data [BLOCK_WORDS],
    output logic              p2_acknowledge,
    output logic              mem_request,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_write_data [BLOCK_WORDS],
    input  logic [WORD_W-1:0] mem_read_data [BLOCK_WORDS],
    input  logic              mem_acknowledge,
    output logic              busy,
    output logic              timeout_error
);

    arb_state_t        state_q, state_d;
    port_id_t          last_grant_q, last_grant_d;
    logic              mem_request_q, mem_request_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [WORD_W-1:0] mem_write_data_q [BLOCK_WORDS];
    logic [WORD_W-1:0] mem_write_data_d [BLOCK_WORDS];
    logic [WORD_W-1:0] p1_read_data_q [BLOCK_WORDS];
    logic [WORD_W-1:0] p1_read_data_d [BLOCK_WORDS];
    logic [WORD_W-1:0] p2_read_data_q [BLOCK_WORDS];
    logic [WORD_W-1:0] p2_read_data_d [BLOCK_WORDS];
    logic              p1_ack_q, p1_ack_d;
    logic              p2_ack_q, p2_ack_d;
    logic              busy_q, busy_d;
    logic              timeout_error_q, timeout_error_d;
    logic              wd_clear, wd_enable, wd_expired;

    assign wd_enable = (state_q == ARB_GRANT1) || (state_q == ARB_GRANT2);

    dram_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        mem_we_d         = mem_we_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        p1_read_data_d   = p1_read_data_q;
        p2_read_data_d   = p2_read_data_q;
        timeout_error_d  = timeout_error_q;
        wd_clear         = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // On a tie the port that did not win last time goes next.
                if (p2_request && (!p1_request || last_grant_q == PORT1)) begin
                    state_d          = ARB_GRANT2;
                    last_grant_d     = PORT2;
                    mem_address_d    = p2_address;
                    mem_we_d         = p2_we;
                    mem_write_data_d = p2_write_data;
                    wd_clear         = 1'b1;
                end else if (p1_request) begin
                    state_d       = ARB_GRANT1;
                    last_grant_d  = PORT1;
                    mem_address_d = p1_address;
                    mem_we_d      = 1'b0;
                    wd_clear      = 1'b1;
                end
            end
            ARB_GRANT1, ARB_GRANT2: begin
                // A late ack beats the watchdog expiring on the same edge.
                if (mem_acknowledge) begin
                    state_d = ARB_DONE;
                    if (state_q == ARB_GRANT1) begin
                        p1_read_data_d = mem_read_data;
                    end else if (!mem_we_q) begin
                        p2_read_data_d = mem_read_data;
                    end
                end else if (wd_expired) begin
                    state_d         = ARB_DONE;
                    timeout_error_d = 1'b1;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase

        mem_request_d = (state_d == ARB_GRANT1) || (state_d == ARB_GRANT2);
        busy_d        = (state_d != ARB_IDLE);
        p1_ack_d      = (state_d == ARB_DONE) && (state_q == ARB_GRANT1);
        p2_ack_d      = (state_d == ARB_DONE) && (state_q == ARB_GRANT2);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= ARB_IDLE;
            last_grant_q     <= PORT1;
            mem_request_q    <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '{default: '0};
            p1_read_data_q   <= '{default: '0};
            p2_read_data_q   <= '{default: '0};
            p1_ack_q         <= 1'b0;
            p2_ack_q         <= 1'b0;
            busy_q           <= 1'b0;
            timeout_error_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            mem_request_q    <= mem_request_d;
            mem_we_q         <= mem_we_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            p1_read_data_q   <= p1_read_data_d;
            p2_read_data_q   <= p2_read_data_d;
            p1_ack_q         <= p1_ack_d;
            p2_ack_q         <= p2_ack_d;
            busy_q           <= busy_d;
            timeout_error_q  <= timeout_error_d;
        end
    end

    assign mem_request    = mem_request_q;
    assign mem_we         = mem_we_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
    assign p1_read_data   = p1_read_data_q;
    assign p2_read_data   = p2_read_data_q;
    assign p1_acknowledge = p1_ack_q;
    assign p2_acknowledge = p2_ack_q;
    assign busy           = busy_q;
    assign timeout_error  = timeout_error_q;

endmodule

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Sequences the single block-transfer DRAM port between the instruction-cache refill port (port 1, read-only) and the data-cache refill/writeback port (port 2, read/write) inside the memory top level. It sits between the two cache controllers and the DRAM controller, one transfer at a time. Round-robin arbitration prevents either cache from starving the other. A watchdog terminates a hung transfer and reports it.

## Interface
- `ADDR_W`, default `DRAM_ADDRESS_SIZE`, block address width.
- `WORD_W`, default `DRAM_WORD_SIZE`, word width.
- `BLOCK_WORDS`, default `DRAM_BLOCK_SIZE`, words per block.
- `TIMEOUT_CYCLES`, default 1024, maximum cycles waiting for `mem_acknowledge`; ≥2.
- `clock` in 1, the only clock, rising edge.
- `reset` in 1, asynchronous, active-low.
- `p1_request` in 1, icache block read request; held until `p1_acknowledge`.
- `p1_address` in ADDR_W, icache block address.
- `p1_read_data` out WORD_W × BLOCK_WORDS (unpacked), icache block read data.
- `p1_acknowledge` out 1, one-cycle completion pulse.
- `p2_request` in 1, dcache request; held until `p2_acknowledge`.
- `p2_address` in ADDR_W, dcache block address.
- `p2_we` in 1, 1 = write, 0 = read.
- `p2_write_data` in WORD_W × BLOCK_WORDS, writeback block.
- `p2_read_data` out WORD_W × BLOCK_WORDS, dcache read block.
- `p2_acknowledge` out 1, one-cycle completion pulse.
- `mem_request` out 1, request to the DRAM controller.
- `mem_address` out ADDR_W, latched address of the granted port.
- `mem_we` out 1, latched write enable; always 0 for port 1.
- `mem_write_data` out WORD_W × BLOCK_WORDS, latched write block.
- `mem_read_data` in WORD_W × BLOCK_WORDS, valid in the cycle `mem_acknowledge`=1.
- `mem_acknowledge` in 1, DRAM transfer done; one-cycle pulse.
- `busy` out 1, high in any state other than IDLE.
- `timeout_error` out 1, sticky; set on watchdog expiry, cleared only by reset.

## Operation
- FSM states: IDLE, GRANT1, GRANT2, DONE.
- **IDLE**
  - No request pending: remain in IDLE.
  - One request pending: grant that port.
  - Both pending: grant the port not recorded in `last_grant`. `last_grant` resets to port 1, so port 2 wins the first tie.
  - On grant:
    - latch address, `we` and write data into the `mem_*` registers (port 1 forces `we`=0);
    - update `last_grant`;
    - clear the watchdog;
    - go to GRANTx.
- **GRANTx**
  - `mem_request`=1; `mem_*` fields held stable.
  - On `mem_acknowledge`:
    - capture `mem_read_data` into `px_read_data` on a read only; on a write, `p2_read_data` keeps its value;
    - go to DONE.
  - The watchdog counts each GRANT cycle. When the count reaches TIMEOUT_CYCLES − 1 without an ack:
    - set `timeout_error`;
    - leave `px_read_data` unchanged;
    - go to DONE.
- **DONE**
  - Assert the granted port's acknowledge for exactly one cycle; `mem_request`=0; go to IDLE.
- Requester rule: deassert `request` in the cycle after `acknowledge`. A request still high in the IDLE cycle after DONE is treated as a new request.
- Requests and `mem_acknowledge` seen while not in the matching GRANT state are ignored.
- A request arriving during a transfer waits. Changes to its address or data before grant are permitted; the values are sampled at grant.
- Watchdog: a `$clog2(TIMEOUT_CYCLES)`-bit counter, saturating, with no wrap.

## Timing
- All outputs registered. Reset value of every output:
  - `p1_read_data`, `p2_read_data`, `mem_address`, `mem_write_data`: all zero;
  - `p1_acknowledge`, `p2_acknowledge`, `mem_request`, `mem_we`: 0;
  - `busy`, `timeout_error`: 0.
- Reset assertion forces state IDLE and `last_grant`=port 1, and zeroes the registered outputs, asynchronously. The transfer in flight is abandoned with no acknowledge.
- A request high at edge N (in IDLE) gives `mem_request`=1 from N+1.
- `mem_acknowledge` sampled at edge M gives `px_acknowledge`=1 and new read data during M..M+1, then IDLE at M+2.
- Latency: request to acknowledge = memory latency + 2 cycles. Minimum back-to-back spacing between grants is 3 cycles (GRANT, DONE, IDLE).
- `mem_acknowledge` and the watchdog expiring on the same edge: the ack wins; no error.

## Structure
- Package `dram_arb_pkg`:
  - `typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_GRANT1, ARB_GRANT2, ARB_DONE}`;
  - `typedef enum logic port_id_t {PORT1, PORT2}`;
  - a block typedef built from `DRAM_WORD_SIZE` / `DRAM_BLOCK_SIZE`.
- Sub-module `dram_arb_watchdog`: clear and enable inputs, `expired` output, parameterised by TIMEOUT_CYCLES.

## Test plan
- Reset, then p1 read of address 0x40 with memory acking after 5 cycles and returning words 0..7 = 0x1000+i:
  - `p1_acknowledge` comes 7 cycles after the request;
  - `p1_read_data[i]` = 0x1000+i;
  - `mem_we`=0.
- p2 write to 0x80 with data 0xA5A5_0000+i:
  - `mem_we`=1, `mem_address`=0x80, `mem_write_data` matches;
  - `p2_read_data` unchanged after `p2_acknowledge`.
- p1 and p2 requesting in the same cycle, each re-requesting immediately after its ack: grants go p2, p1, p2, p1; neither port is granted twice in a row.
- Memory never acks with TIMEOUT_CYCLES=16:
  - acknowledge 17 cycles after the grant edge, with `timeout_error`=1;
  - `timeout_error` stays 1 for the following transfers until reset.
- Reset asserted mid-GRANT2:
  - `mem_request` and `busy` drop with no clock edge;
  - no `p2_acknowledge`;
  - after release, a tie is granted to p2.
- Ack and watchdog expiry on the same edge: data captured, `timeout_error`=0.
